layer_input_buffer: RTL

//  Upstream stage of a neuron/layer. Collects a serial stream of fixed_point words over a valid/ready handshake.

---
 rtl/layer_input_buffer_if.sv | 26 ++
 rtl/layer_input_buffer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/layer_input_buffer_if.sv
// Serial word stream feeding a layer input buffer.
// A word moves on a rising clock edge when in_valid and in_ready are both high; in_data/in_last are ignored otherwise.
`timescale 1ns/1ps

interface layer_input_buffer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/layer_input_buffer.sv
// Collects a serial stream of fixed-point words into a parallel vector for a neuron,
// pulses outputs_ready once per frame and holds the vector until the consumer is done.
`timescale 1ns/1ps

module layer_input_buffer #(
    parameter int NUM_INPUTS     = 16,
    parameter int COUNT_WIDTH    = 16,
    parameter int INTEGRAL_WIDTH = 8,
    parameter int FRACTION_WIDTH = 8,
    localparam int DATA_WIDTH    = INTEGRAL_WIDTH + FRACTION_WIDTH
) (
    input  logic                                  clock,
    input  logic                                  reset,
    layer_input_buffer_if.slave                   in_if,
    output logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] outputs,
    output logic                                  outputs_ready,
    input  logic                                  consumer_done,
    output logic                                  length_error,
    output logic [COUNT_WIDTH-1:0]                frame_count,
    output logic [1:0]                            state_dbg
);

    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

    typedef enum logic [1:0] {
        FILLING = 2'd0,
        ISSUE   = 2'd1,
        BUSY    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] index;
    logic             in_ready;
    logic             transfer;
    logic             at_last;
    logic             frame_end;
    logic             frame_bad;

    // in_ready depends on the state register (and reset) only, never on in_valid.
    assign in_ready       = (state == FILLING) && !reset;
    assign in_if.in_ready = in_ready;
    assign transfer       = in_if.in_valid && in_ready;

    // A frame closes on the last slot or on in_last; it is malformed when those two disagree.
    assign at_last   = (index == LAST_IDX);
    assign frame_end = at_last || in_if.in_last;
    assign frame_bad = at_last ^ in_if.in_last;

    assign outputs_ready = (state == ISSUE);
    assign state_dbg     = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FILLING;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILLING: begin
                if (transfer && frame_end) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = BUSY;
            end
            BUSY: begin
                if (consumer_done) begin
                    state_next = FILLING;
                end
            end
            default: begin
                state_next = FILLING;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            index        <= '0;
            outputs      <= '0;
            length_error <= 1'b0;
            frame_count  <= '0;
        end else begin
            case (state)
                FILLING: begin
                    if (transfer) begin
                        outputs[index] <= in_if.in_data;
                        if (frame_end) begin
                            index <= '0;
                            if (frame_bad) begin
                                length_error <= 1'b1;
                            end
                        end else begin
                            index <= index + IDX_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    frame_count <= frame_count + COUNT_WIDTH'(1);
                end
                BUSY: begin
                    // Clearing here means a short next frame leaves its unwritten slots at zero.
                    if (consumer_done) begin
                        outputs <= '0;
                        index   <= '0;
                    end
                end
                default: begin
                    outputs <= '0;
                    index   <= '0;
                end
            endcase
        end
    end

endmodule
